// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: address/control sequencer for the high-frequency FIR path.
//
// On each accepted sample (wrt_smpl while the queue is primed) it walks the
// sample-queue read address from the oldest sample across TAPS entries with
// circular wrap. It steps the coefficient ROM address in lockstep and drives
// the accumulator clear/enable. The RAM and ROM have one cycle of registered
// read latency, so acc_en trails the address by one cycle.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   wrt_smpl    - one-cycle pulse, new sample written to the queue
//   q_full      - queue primed; sequencing is allowed
//   old_ptr     - address of the oldest valid sample, captured at start
//   rd_addr     - queue read address (registered)
//   coeff_addr  - coefficient ROM address (registered)
//   acc_clr     - one-cycle accumulator clear
//   acc_en      - accumulate the current RAM x ROM product
//   busy        - sequence in progress
//   done        - one-cycle pulse, accumulator holds a complete result
//   ovr         - sticky overrun (sample arrived while busy)
module fir_seq_ctrl #(
  parameter int unsigned DEPTH = 1536,
  parameter int unsigned TAPS  = 1021,
  parameter int unsigned AW    = 11,
  parameter int unsigned CW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wrt_smpl,
  input  logic          q_full,
  input  logic [AW-1:0] old_ptr,
  output logic [AW-1:0] rd_addr,
  output logic [CW-1:0] coeff_addr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          busy,
  output logic          done,
  output logic          ovr
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LastTap  = CW'(TAPS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0] coeff_addr_q, coeff_addr_d;
  logic [CW-1:0] tap_q, tap_d;
  logic          acc_clr_q, acc_clr_d;
  logic          acc_en_q, acc_en_d;
  logic          ovr_q, ovr_d;

  logic          start;
  logic          in_seq;

  assign in_seq = (state_q == StRun) || (state_q == StDrain);
  // A new start is only accepted once the previous result is out (IDLE/DONE).
  assign start  = wrt_smpl && q_full && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    coeff_addr_d = coeff_addr_q;
    tap_d        = tap_q;
    acc_clr_d    = start;
    // Address issued in RUN is read back one cycle later.
    acc_en_d     = (state_q == StRun);
    // Overrun: the running sequence is left untouched, only flagged.
    ovr_d        = ovr_q || (wrt_smpl && in_seq);

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StRun;
          rd_addr_d    = old_ptr;
          coeff_addr_d = '0;
          tap_d        = '0;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (tap_q == LastTap) begin
          state_d = StDrain;
        end else begin
          tap_d        = tap_q + 1'b1;
          coeff_addr_d = coeff_addr_q + 1'b1;
          rd_addr_d    = (rd_addr_q == LastAddr) ? '0 : rd_addr_q + 1'b1;
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rd_addr_q    <= '0;
      coeff_addr_q <= '0;
      tap_q        <= '0;
      acc_clr_q    <= 1'b0;
      acc_en_q     <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      coeff_addr_q <= coeff_addr_d;
      tap_q        <= tap_d;
      acc_clr_q    <= acc_clr_d;
      acc_en_q     <= acc_en_d;
      ovr_q        <= ovr_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign coeff_addr = coeff_addr_q;
  assign acc_clr    = acc_clr_q;
  assign acc_en     = acc_en_q;
  assign busy       = in_seq;
  assign done       = (state_q == StDone);
  assign ovr        = ovr_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl: each start pushes its full expected event
// stream (clear, TAPS accumulates, done) with cycle stamps; a monitor pops and
// compares whenever the DUT shows acc_clr, acc_en or done.
module tb_fir_seq_ctrl;
  localparam int DEPTH = 1536;
  localparam int TAPS  = 1021;
  localparam int AW    = 11;
  localparam int CW    = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wrt_smpl = 1'b0;
  logic          q_full = 1'b0;
  logic [AW-1:0] old_ptr = '0;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] coeff_addr;
  logic          acc_clr, acc_en, busy, done, ovr;

  fir_seq_ctrl #(.DEPTH(DEPTH), .TAPS(TAPS), .AW(AW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_smpl   (wrt_smpl),
    .q_full     (q_full),
    .old_ptr    (old_ptr),
    .rd_addr    (rd_addr),
    .coeff_addr (coeff_addr),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .busy       (busy),
    .done       (done),
    .ovr        (ovr)
  );

  always #5 clk = ~clk;

  typedef enum int {EvClr, EvAcc, EvDone} ev_e;
  typedef struct {
    ev_e kind;
    int  rd;
    int  co;
    int  bsy;
    int  cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every presented DUT event against the scoreboard head.
  int prev_rd = 0, prev_co = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_clr && acc_en) chk("clr_en_overlap", 1, 0);
      if (acc_clr) pop_cmp(EvClr, int'(rd_addr), int'(coeff_addr));
      // acc_en accumulates the data for the previous cycle's address
      if (acc_en) pop_cmp(EvAcc, prev_rd, prev_co);
      if (done) pop_cmp(EvDone, int'(rd_addr), int'(coeff_addr));
    end
    prev_rd = int'(rd_addr);
    prev_co = int'(coeff_addr);
  end

  task automatic pop_cmp(input ev_e kind, input int rd, input int co);
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    if (kind != e.kind || rd != e.rd || co != e.co || int'(busy) != e.bsy || cyc != e.cyc) begin
      errors++;
      $display("FAIL event: got kind=%0d rd=%0d co=%0d busy=%0d cyc=%0d expected kind=%0d rd=%0d co=%0d busy=%0d cyc=%0d",
               kind, rd, co, busy, cyc, e.kind, e.rd, e.co, e.bsy, e.cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_run(input int ptr, input int s);
    exp_q.push_back('{EvClr, ptr, 0, 1, s + 1});
    for (int k = 0; k < TAPS; k++)
      exp_q.push_back('{EvAcc, (ptr + k) % DEPTH, k, 1, s + 2 + k});
    exp_q.push_back('{EvDone, (ptr + TAPS - 1) % DEPTH, TAPS - 1, 0, s + TAPS + 2});
  endtask

  // Issue a start pulse in the current cycle; returns S.
  task automatic start_run(input int ptr, output int s);
    s        = cyc;
    old_ptr  = AW'(ptr);
    q_full   = 1'b1;
    wrt_smpl = 1'b1;
    push_run(ptr, s);
    step();
    wrt_smpl = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (4) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_coeff"}, int'(coeff_addr), 0);
    chk({tag, "_acc_clr"}, int'(acc_clr), 0);
    chk({tag, "_acc_en"}, int'(acc_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ovr"}, int'(ovr), 0);
  endtask

  int s;

  initial begin
    // Reset state
    #3;
    chk_reset_vals("reset");
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Not primed: pulses ignored
    q_full = 1'b0;
    old_ptr = AW'(11'h155);
    for (int i = 0; i < 3; i++) begin
      wrt_smpl = 1'b1;
      step();
      wrt_smpl = 1'b0;
      step();
    end
    repeat (3) step();
    chk_reset_vals("not_primed");

    // Nominal run
    start_run(32'h100, s);
    wait_drain();
    chk("nominal_busy_after", int'(busy), 0);
    chk("nominal_ovr", int'(ovr), 0);

    // Back-to-back: second start in the done cycle
    start_run(32'h100, s);
    wait_cyc(s + TAPS + 2);
    start_run(32'h101, s);
    wait_drain();
    chk("b2b_ovr", int'(ovr), 0);

    // Wrap across DEPTH-1 -> 0
    start_run(1400, s);
    wait_drain();
    chk("wrap_ovr", int'(ovr), 0);

    // Overrun at S+500: flagged, sequence unaltered, no second run
    start_run(32'h100, s);
    wait_cyc(s + 500);
    wrt_smpl = 1'b1;
    step();
    wrt_smpl = 1'b0;
    @(negedge clk);
    chk("ovr_set", int'(ovr), 1);
    step();
    wait_drain();
    repeat (20) step();
    chk("ovr_sticky", int'(ovr), 1);
    chk("ovr_no_rerun_busy", int'(busy), 0);

    // Reset mid-run at S+300
    start_run(0, s);
    wait_cyc(s + 300);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_vals("midrun_reset");
    step();
    rst_n = 1'b1;
    step();
    start_run(0, s);
    wait_drain();
    chk("post_reset_ovr", int'(ovr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencer for the high-frequency FIR path. On each accepted audio sample, it walks the sample queue's dual-port RAM read address from the oldest stored sample across TAPS consecutive entries, with circular wrap. In lockstep it steps the coefficient ROM address and drives the MAC accumulator controls. It sits between the high-frequency sample queue (its read port and `old_ptr`/full status), the coefficient ROM and the multiply-accumulate datapath.

## Interface
- DEPTH, 1536: queue depth in samples; read address wraps DEPTH-1 -> 0.
- TAPS, 1021: products per output sample; TAPS <= DEPTH.
- AW, 11: queue address width; 2^AW >= DEPTH.
- CW, 10: coefficient address width; 2^CW >= TAPS.

- clk  in  1  system clock; reset rst_n, asynchronous, active-low; clock clk.
- rst_n  in  1  asynchronous active-low reset.
- wrt_smpl  in  1  one-cycle pulse, a new sample is written into the queue this cycle.
- q_full  in  1  queue has been primed (sequencing); level.
- old_ptr  in  AW  queue address of the oldest valid sample; sampled only at start.
- rd_addr  out  AW  queue read address (registered).
- coeff_addr  out  CW  coefficient ROM address (registered).
- acc_clr  out  1  clear accumulator (one-cycle pulse).
- acc_en  out  1  accumulate product of RAM/ROM data this cycle.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse, accumulator holds a complete result.
- ovr  out  1  sticky overrun flag.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Start condition: wrt_smpl=1 and q_full=1 at a clock edge while in IDLE or DONE.
- On start:
  - base <= old_ptr; rd_addr <= old_ptr; coeff_addr <= 0; tap counter <= 0; acc_clr <= 1.
  - Enter RUN.
- RUN:
  - Each cycle, rd_addr advances by +1 mod DEPTH: if rd_addr == DEPTH-1, the next value is 0.
  - coeff_addr advances by +1 each cycle.
  - When the tap counter reaches TAPS-1, the address stops advancing and the state becomes DRAIN.
- DRAIN: one cycle for the final product. Next state is DONE.
- DONE: one cycle, done=1. If there is no start, the next state is IDLE.
- acc_en is the one-cycle-delayed "address valid" flag, matching the 1-cycle registered read latency of the RAM and ROM.
- rd_addr and coeff_addr hold their last values in IDLE/DONE.
- wrt_smpl while q_full=0: ignored, no state change.
- q_full deasserting mid-sequence: ignored; the sequence completes.
- wrt_smpl during RUN or DRAIN (overrun):
  - ovr <= 1 (sticky until reset).
  - The current sequence continues unaltered; no restart, no queued start.
- Reset mid-operation: immediately returns to IDLE; all outputs take their reset values; ovr cleared.
- Reset values: rd_addr=0, coeff_addr=0, acc_clr=0, acc_en=0, busy=0, done=0, ovr=0.

## Timing
Let S = the cycle in which start is sampled.
- S+1: acc_clr=1, busy=1, rd_addr=base, coeff_addr=0.
- S+1+k for k=0..TAPS-1: rd_addr=(base+k) mod DEPTH, coeff_addr=k.
- acc_en=1 in cycles S+2..S+TAPS+1 (exactly TAPS cycles). The DRAIN cycle is S+TAPS+1.
- busy=1 in cycles S+1..S+TAPS+1.
- done=1 only in cycle S+TAPS+2; busy=0 in that cycle.
- acc_clr and acc_en are never high in the same cycle.
- Back-to-back operation: a start sampled in the DONE cycle gives the next S+1 immediately after done. Minimum start-to-start spacing is TAPS+2 cycles.
- Total latency from start to done: TAPS+2 cycles (1023 at defaults).

## Test plan
- Nominal run: defaults, q_full=1, old_ptr=0x100, wrt_smpl pulse -> acc_clr at S+1; rd_addr 0x100..0x4FC and coeff_addr 0..1020 over S+1..S+1021; exactly 1021 acc_en cycles; done at S+1023; busy low afterwards.
- Wrap: old_ptr=1400 -> rd_addr steps 1400..1535, then 0..884; coeff_addr continuous 0..1020; no skipped or repeated address.
- Not primed: q_full=0 with several wrt_smpl pulses -> busy, acc_clr, acc_en and done all stay 0; rd_addr stays 0.
- Overrun: second wrt_smpl at S+500 -> ovr=1 from S+501 and stays set; address sequence and done timing are identical to the nominal run; no second run follows.
- Back-to-back: wrt_smpl asserted in the done cycle with old_ptr=0x101 -> acc_clr and rd_addr=0x101 on the next cycle; ovr stays 0.
- Reset mid-run: rst_n low at S+300 -> all outputs go to reset values asynchronously; after release, a new start at old_ptr=0 runs a full TAPS sequence correctly.
